seq_detector_0101: RTL and testbench
====================================

SEQ_DETECTOR_0101 -- requirements
Module: seq_detector_0101

Interface
REQ-001 Parameter OVERLAP, default 1, meaning 1 = overlapping detection, 0 = non-overlapping (the matched pattern is fully consumed).
REQ-002 Parameter CNT_W, default 8, meaning width of the detection counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port x, input, 1 bit: serial data bit, sampled on each rising clk edge.
REQ-006 Port y_mealy, output, 1 bit: Mealy detection flag, combinational from state and x.
REQ-007 Port y_moore, output, 1 bit: Moore detection flag, a function of registered state only.
REQ-008 Port match_cnt, output, CNT_W bits: count of Mealy detections since reset.

Function
REQ-009 The detected pattern SHALL be the serial sequence 0,1,0,1, oldest bit first.
REQ-010 Mealy FSM states SHALL be M0 (no progress), M1 ("0"), M2 ("01") and M3 ("010").
REQ-011 Mealy transitions: M0 x0->M1, x1->M0; M1 x0->M1, x1->M2; M2 x0->M3, x1->M0; M3 x0->M1, x1->M2 when OVERLAP=1 or M0 when OVERLAP=0.
REQ-012 y_mealy SHALL be 1 exactly when the state is M3, x=1 and reset=0; otherwise it SHALL be 0 (zero-cycle latency, valid before the completing edge).
REQ-013 Moore FSM states SHALL be S0, S1 ("0"), S2 ("01"), S3 ("010") and S4 ("0101" detected).
REQ-014 Moore transitions for S0..S2 SHALL match M0..M2; S3 x0->S1, x1->S4.
REQ-015 S4 transitions SHALL be x0->S3, x1->S0 when OVERLAP=1, and x0->S1, x1->S0 when OVERLAP=0.
REQ-016 y_moore SHALL be 1 exactly while the state is S4, i.e. for one full cycle after the edge that samples the final 1 (one-cycle latency relative to y_mealy).
REQ-017 Both FSMs SHALL see the same x and clock, so each y_moore pulse SHALL follow a y_mealy pulse by exactly one cycle.
REQ-018 match_cnt SHALL increment by 1 on every rising edge where y_mealy=1.
REQ-019 match_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 An x value that is unknown (X or Z) SHALL be treated as 0 for transitions; this is a simulation-only concern.

Reset
REQ-021 Asserting reset SHALL immediately force both FSMs to their idle states (M0, S0), independent of clk.
REQ-022 On reset, y_moore, y_mealy and match_cnt SHALL immediately be 0.
REQ-023 While reset=1, the state SHALL hold at idle and y_mealy SHALL stay 0 regardless of x.
REQ-024 Asserting reset mid-pattern SHALL discard partial progress, so the first rising edge after deassertion starts from idle.

Structure
REQ-025 A shared package seq_0101_pkg SHALL hold the Mealy and Moore state enum typedefs and the pattern constant 4'b0101.
REQ-026 Two sub-modules SHALL implement the FSMs: mealy_0101 (ports y, x, clk, reset) and moore_0101 (same ports).
REQ-027 The top SHALL instantiate both sub-modules and contain the saturating counter.
REQ-028 The states SHALL use binary encoding, with the next-state logic and output logic separated from the state register.

Verification
REQ-029 Sequence 0,0,1,0,0,1,0,1 after reset release -> y_mealy=1 only during the 8th bit (before its edge); y_moore=1 only in the following cycle; match_cnt=1.
REQ-030 Sequence 0,1,0,1,0,1,0,1 with OVERLAP=1 -> y_mealy pulses on bits 4, 6 and 8; match_cnt=3; y_moore pulses one cycle after each.
REQ-031 The same sequence with OVERLAP=0 -> pulses on bits 4 and 8 only; match_cnt=2.
REQ-032 Sequence 0,1,0, then assert reset asynchronously between edges, release it, then apply 1 -> no detection; state is idle; match_cnt stays 0.
REQ-033 CNT_W=2 with repeated 0101 patterns -> match_cnt reaches 3 and holds at 3.
REQ-034 Sequence 1,1,1,0,0,0,1,1 -> y_mealy and y_moore stay 0 throughout.

Source files
------------

// File: rtl/seq_0101_pkg.sv
// Shared types and constants for the 0101 serial pattern detectors.
package seq_0101_pkg;

    localparam logic [3:0] PATTERN = 4'b0101;

    typedef enum logic [1:0] {
        M0,
        M1,
        M2,
        M3
    } mealy_state_t;

    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4
    } moore_state_t;

    // Unknown input bits steer the FSMs as if they were 0.
    function automatic logic known_bit(input logic b);
        case (b)
            1'b1:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mealy_0101.sv
// Mealy detector for 0101: flag is raised combinationally on the completing bit.
module mealy_0101
    import seq_0101_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    output logic y,
    input  logic x,
    input  logic clk,
    input  logic reset
);

    mealy_state_t r_state;
    mealy_state_t w_next;
    logic         w_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= M0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_x    = known_bit(x);
        w_next = r_state;
        y      = 1'b0;
        case (r_state)
            M0: w_next = w_x ? M0 : M1;
            M1: w_next = w_x ? M2 : M1;
            M2: w_next = w_x ? M0 : M3;
            M3: begin
                if (w_x) begin
                    w_next = (OVERLAP != 0) ? M2 : M0;
                    y      = ~reset;
                end else begin
                    w_next = M1;
                end
            end
            default: w_next = M0;
        endcase
    end

endmodule

// File: rtl/moore_0101.sv
// Moore detector for 0101: flag is a decode of the registered "detected" state.
module moore_0101
    import seq_0101_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    output logic y,
    input  logic x,
    input  logic clk,
    input  logic reset
);

    moore_state_t r_state;
    moore_state_t w_next;
    logic         w_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_x    = known_bit(x);
        w_next = r_state;
        case (r_state)
            S0: w_next = w_x ? S0 : S1;
            S1: w_next = w_x ? S2 : S1;
            S2: w_next = w_x ? S0 : S3;
            S3: w_next = w_x ? S4 : S1;
            // With overlap the trailing "01" of a match is reused as progress.
            S4: begin
                if (w_x) begin
                    w_next = S0;
                end else begin
                    w_next = (OVERLAP != 0) ? S3 : S1;
                end
            end
            default: w_next = S0;
        endcase
    end

    always_comb begin
        y = (r_state == S4);
    end

endmodule

// File: rtl/seq_detector_0101.sv
// 0101 detector top: Mealy and Moore FSMs on a shared input plus a saturating match counter.
module seq_detector_0101
    import seq_0101_pkg::*;
#(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    output logic             y_mealy,
    output logic             y_moore,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_y_mealy;
    logic             w_y_moore;
    logic [CNT_W-1:0] r_cnt;

    mealy_0101 #(
        .OVERLAP(OVERLAP)
    ) u_mealy (
        .y    (w_y_mealy),
        .x    (x),
        .clk  (clk),
        .reset(reset)
    );

    moore_0101 #(
        .OVERLAP(OVERLAP)
    ) u_moore (
        .y    (w_y_moore),
        .x    (x),
        .clk  (clk),
        .reset(reset)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_y_mealy && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    always_comb begin
        y_mealy   = w_y_mealy;
        y_moore   = w_y_moore;
        match_cnt = r_cnt;
    end

endmodule

// File: tb/tb_seq_detector_0101.sv
// Scoreboard bench: three detector configurations share one input stream against a shift-history model.
module tb_seq_detector_0101;

    logic       clk;
    logic       reset;
    logic       x;
    logic       m_ov, m_no, m_sat;
    logic       o_ov, o_no, o_sat;
    logic [7:0] c_ov, c_no;
    logic [1:0] c_sat;

    typedef struct packed {
        logic       m_ov;
        logic       m_no;
        logic       m_sat;
        logic       o_ov;
        logic       o_no;
        logic       o_sat;
        logic [7:0] c_ov;
        logic [7:0] c_no;
        logic [1:0] c_sat;
    } obs_t;

    obs_t q_exp[$];

    int unsigned checks;
    int unsigned passes;

    logic [2:0] h_ov, h_no;
    int         len_ov, len_no;
    logic       prev_ov, prev_no;
    int         cnt_ov, cnt_no, cnt_sat;

    seq_detector_0101 #(.OVERLAP(1), .CNT_W(8)) u_ov (
        .clk(clk), .reset(reset), .x(x),
        .y_mealy(m_ov), .y_moore(o_ov), .match_cnt(c_ov)
    );
    seq_detector_0101 #(.OVERLAP(0), .CNT_W(8)) u_no (
        .clk(clk), .reset(reset), .x(x),
        .y_mealy(m_no), .y_moore(o_no), .match_cnt(c_no)
    );
    seq_detector_0101 #(.OVERLAP(1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .x(x),
        .y_mealy(m_sat), .y_moore(o_sat), .match_cnt(c_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t s;
        s.m_ov  = m_ov;
        s.m_no  = m_no;
        s.m_sat = m_sat;
        s.o_ov  = o_ov;
        s.o_no  = o_no;
        s.o_sat = o_sat;
        s.c_ov  = c_ov;
        s.c_no  = c_no;
        s.c_sat = c_sat;
        return s;
    endfunction

    task automatic model_reset();
        h_ov = '0; h_no = '0;
        len_ov = 0; len_no = 0;
        prev_ov = 1'b0; prev_no = 1'b0;
        cnt_ov = 0; cnt_no = 0; cnt_sat = 0;
    endtask

    // Drive one bit at the falling edge, push the expectation for the coming
    // rising edge, then advance the model past that edge.
    task automatic drive_bit(input logic b);
        obs_t e;
        logic det_ov, det_no;
        @(negedge clk);
        x = b;
        det_ov = (len_ov >= 3) && ({h_ov, b} == 4'b0101);
        det_no = (len_no >= 3) && ({h_no, b} == 4'b0101);
        e.m_ov  = det_ov;
        e.m_no  = det_no;
        e.m_sat = det_ov;
        e.o_ov  = prev_ov;
        e.o_no  = prev_no;
        e.o_sat = prev_ov;
        e.c_ov  = 8'(cnt_ov);
        e.c_no  = 8'(cnt_no);
        e.c_sat = 2'(cnt_sat);
        q_exp.push_back(e);
        h_ov   = {h_ov[1:0], b};
        len_ov = (len_ov < 3) ? len_ov + 1 : 3;
        if (det_no) begin
            h_no   = '0;
            len_no = 0;
        end else begin
            h_no   = {h_no[1:0], b};
            len_no = (len_no < 3) ? len_no + 1 : 3;
        end
        prev_ov = det_ov;
        prev_no = det_no;
        if (det_ov && cnt_ov < 255) cnt_ov++;
        if (det_no && cnt_no < 255) cnt_no++;
        if (det_ov && cnt_sat < 3) cnt_sat++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        x     = 1'b0;
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        reset = 1'b1;
        x     = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        o = sample();
        checks++;
        if (o !== obs_t'(0)) $display("FAIL reset_idle obs=%h exp=%h", o, obs_t'(0));
        else passes++;
        #2;
        reset = 1'b0;
    endtask

    task automatic run_bits(input string name, input logic [31:0] bits, input int n);
        obs_t o, e;
        for (int i = n - 1; i >= 0; i--) begin
            drive_bit(bits[i]);
            #1;
            o = sample();
            e = q_exp.pop_front();
            checks++;
            if (o !== e) $display("FAIL %s bit%0d obs=%h exp=%h", name, n - i, o, e);
            else passes++;
        end
    endtask

    task automatic test_single();
        do_reset();
        run_bits("single", 32'b0_0100_1011, 9);
        checks++;
        if (c_ov !== 8'd1 || c_no !== 8'd1) $display("FAIL single_cnt obs=%0d/%0d exp=1/1", c_ov, c_no);
        else passes++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_bits("overlap", 32'b0_1010_1010, 9);
        checks++;
        if (c_ov !== 8'd3 || c_no !== 8'd2) $display("FAIL overlap_cnt obs=%0d/%0d exp=3/2", c_ov, c_no);
        else passes++;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        do_reset();
        run_bits("mid_pre", 32'b010, 3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        x     = 1'b1;
        model_reset();
        #1;
        o = sample();
        checks++;
        if (o !== obs_t'(0)) $display("FAIL mid_reset obs=%h exp=%h", o, obs_t'(0));
        else passes++;
        #1;
        reset = 1'b0;
        run_bits("mid_post", 32'b10, 2);
        checks++;
        if (c_ov !== 8'd0 || c_no !== 8'd0) $display("FAIL mid_cnt obs=%0d/%0d exp=0/0", c_ov, c_no);
        else passes++;
    endtask

    task automatic test_saturation();
        do_reset();
        run_bits("sat", 32'b0101_0101_0101_0101_0101_1, 21);
        checks++;
        if (c_sat !== 2'd3 || c_ov !== 8'd9) $display("FAIL sat_cnt obs=%0d/%0d exp=3/9", c_sat, c_ov);
        else passes++;
    endtask

    task automatic test_no_match();
        do_reset();
        run_bits("nomatch", 32'b1110_0011, 8);
        checks++;
        if (c_ov !== 8'd0 || c_no !== 8'd0) $display("FAIL nomatch_cnt obs=%0d/%0d exp=0/0", c_ov, c_no);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset  = 1'b1;
        x      = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        test_no_match();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
